// File: rtl/midi_in.sv
// MIDI serial receiver and channel-voice parser with running status.
// Emits one-cycle note on/off events for the downstream player.
module midi_in #(
    parameter int CLK_HZ  = 12000000,
    parameter int BAUD    = 31250,
    parameter int CHANNEL = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] midi_data,
    output logic       midi_valid,
    output logic       note_on,
    output logic [6:0] velocity,
    output logic       framing_error
);

    localparam int CPB   = CLK_HZ / BAUD;
    localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [3:0] CH_SEL = 4'(CHANNEL % 16);
    localparam logic       OMNI   = (CHANNEL >= 16);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t r_state;
    rx_state_t w_state_nxt;

    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_byte;
    logic             r_byte_stb;
    logic             r_ferr_pre;

    logic [7:0] r_rs;
    logic       r_have_d1;
    logic [6:0] r_d1;

    logic [7:0] r_midi_data;
    logic       r_midi_valid;
    logic       r_note_on;
    logic [6:0] r_velocity;
    logic       r_framing_error;

    logic w_tick_half;
    logic w_tick_bit;
    logic w_cnt_clr;
    logic w_shift_en;
    logic w_byte_done;
    logic w_frame_err;

    logic w_need_one;
    logic w_data_ok;
    logic w_note_msg;
    logic w_ch_match;
    logic w_emit;

    assign w_tick_half = (r_cnt == HALF_LAST);
    assign w_tick_bit  = (r_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A line held low after a framing error gives no falling edge,
    // so a break cannot retrigger the receiver.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RX_IDLE: begin
                if (r_rx_prev && !r_rx_sync) begin
                    w_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (w_tick_half) begin
                    w_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_tick_bit && (r_bit_idx == 3'd7)) begin
                    w_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_tick_bit) begin
                    w_state_nxt = RX_IDLE;
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_clr   = 1'b0;
        w_shift_en  = 1'b0;
        w_byte_done = 1'b0;
        w_frame_err = 1'b0;
        unique case (r_state)
            RX_IDLE:  w_cnt_clr = 1'b1;
            RX_START: w_cnt_clr = w_tick_half;
            RX_DATA: begin
                w_cnt_clr  = w_tick_bit;
                w_shift_en = w_tick_bit;
            end
            RX_STOP: begin
                w_cnt_clr   = w_tick_bit;
                w_byte_done = w_tick_bit && r_rx_sync;
                w_frame_err = w_tick_bit && !r_rx_sync;
            end
            default: w_cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_byte     <= '0;
            r_byte_stb <= 1'b0;
            r_ferr_pre <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            r_byte_stb <= w_byte_done;
            r_ferr_pre <= w_frame_err;
            if (r_state != RX_DATA) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_shift_en) begin
                r_shift <= {r_rx_sync, r_shift[7:1]};
            end
            if (w_byte_done) begin
                r_byte <= r_shift;
            end
        end
    end

    assign w_need_one = (r_rs[7:4] == 4'hC) || (r_rs[7:4] == 4'hD);
    assign w_data_ok  = r_byte_stb && !r_byte[7] && (r_rs != 8'h00);
    assign w_note_msg = (r_rs[7:5] == 3'b100);
    assign w_ch_match = OMNI || (r_rs[3:0] == CH_SEL);
    assign w_emit     = w_data_ok && r_have_d1 && w_note_msg && w_ch_match;

    // Realtime bytes (F8-FF) leave the parser untouched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rs      <= '0;
            r_have_d1 <= 1'b0;
            r_d1      <= '0;
        end else if (r_byte_stb) begin
            if (r_byte[7]) begin
                if (r_byte[7:3] != 5'b11111) begin
                    r_have_d1 <= 1'b0;
                    r_rs      <= (r_byte[7:4] == 4'hF) ? 8'h00 : r_byte;
                end
            end else if (r_rs != 8'h00) begin
                if (r_have_d1 || w_need_one) begin
                    r_have_d1 <= 1'b0;
                end else begin
                    r_d1      <= r_byte[6:0];
                    r_have_d1 <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_midi_data     <= '0;
            r_midi_valid    <= 1'b0;
            r_note_on       <= 1'b0;
            r_velocity      <= '0;
            r_framing_error <= 1'b0;
        end else begin
            r_midi_valid    <= w_emit;
            r_framing_error <= r_ferr_pre;
            if (w_emit) begin
                r_midi_data <= {1'b0, r_d1};
                r_note_on   <= r_rs[4] && (r_byte[6:0] != 7'd0);
                r_velocity  <= r_byte[6:0];
            end
        end
    end

    assign midi_data     = r_midi_data;
    assign midi_valid    = r_midi_valid;
    assign note_on       = r_note_on;
    assign velocity      = r_velocity;
    assign framing_error = r_framing_error;

endmodule

// File: tb/tb_midi_in.sv
// Bench for midi_in: omni and channel-2 instances share one serial line.
// Table vectors, corner sequences and random bytes against a parser model.
module tb_midi_in;

    localparam int CLK_HZ = 500000;
    localparam int BAUD   = 31250;
    localparam int CPB    = CLK_HZ / BAUD;

    typedef logic [15:0] ev_t;

    typedef struct {
        int          n;
        logic [47:0] b;
        int          no;
        int          nc;
        ev_t         ev;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;

    logic [7:0] md_o, md_c;
    logic       v_o, v_c;
    logic       on_o, on_c;
    logic [6:0] vel_o, vel_c;
    logic       fe_o_s, fe_c_s;

    midi_in #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(16)) u_omni (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .midi_data(md_o), .midi_valid(v_o), .note_on(on_o),
        .velocity(vel_o), .framing_error(fe_o_s)
    );

    midi_in #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .CHANNEL(2)) u_ch2 (
        .clk(clk), .rst_n(rst_n), .rx(rx),
        .midi_data(md_c), .midi_valid(v_c), .note_on(on_c),
        .velocity(vel_c), .framing_error(fe_c_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t  obs_o[$];
    ev_t  obs_c[$];
    int   fe_cnt_o = 0;
    int   fe_cnt_c = 0;
    int   bb = 0;
    int   t_val = 0;
    logic pv_o = 1'b0;
    logic pv_c = 1'b0;

    always @(negedge clk) begin
        if (v_o) begin
            obs_o.push_back({md_o, on_o, vel_o});
            t_val = cyc;
            if (pv_o) bb++;
        end
        if (v_c) begin
            obs_c.push_back({md_c, on_c, vel_c});
            if (pv_c) bb++;
        end
        if (fe_o_s) fe_cnt_o++;
        if (fe_c_s) fe_cnt_c++;
        pv_o = v_o;
        pv_c = v_c;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int t_stop   = 0;
    ev_t exp_o[$];
    ev_t exp_c[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            hold(CPB);
        end
        rx = stop;
        t_stop = cyc;
        hold(CPB);
    endtask

    // Message-level reference: collect data bytes per status, complete on count.
    function automatic void model(input logic [7:0] bs[$]);
        logic [7:0] rs;
        logic [7:0] dq[$];
        int need;
        ev_t e;
        rs = 8'h00;
        exp_o.delete();
        exp_c.delete();
        foreach (bs[k]) begin
            if (bs[k] >= 8'hF8) continue;
            if (bs[k] >= 8'hF0) begin
                rs = 8'h00;
                dq.delete();
                continue;
            end
            if (bs[k] >= 8'h80) begin
                rs = bs[k];
                dq.delete();
                continue;
            end
            if (rs == 8'h00) continue;
            dq.push_back(bs[k]);
            need = (rs[7:4] == 4'hC || rs[7:4] == 4'hD) ? 1 : 2;
            if (dq.size() == need) begin
                if (rs[7:4] == 4'h8 || rs[7:4] == 4'h9) begin
                    e = {dq[0], (rs[7:4] == 4'h9) && (dq[1] != 8'h00), dq[1][6:0]};
                    exp_o.push_back(e);
                    if (rs[3:0] == 4'd2) exp_c.push_back(e);
                end
                dq.delete();
            end
        end
    endfunction

    initial begin
        #600000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    vec_t vt[10];
    logic [7:0] rbytes[$];

    initial begin
        int bo, bc, fo, fc, d, k;
        logic [3:0] hi;
        logic [7:0] b;

        vt[0] = '{3, 48'h903C64000000, 1, 0, {8'h3C, 1'b1, 7'h64}};
        vt[1] = '{5, 48'h903C64400000, 2, 0, {8'h40, 1'b0, 7'h00}};
        vt[2] = '{4, 48'h803CF8200000, 1, 0, {8'h3C, 1'b0, 7'h20}};
        vt[3] = '{3, 48'h913C64000000, 1, 0, {8'h3C, 1'b1, 7'h64}};
        vt[4] = '{3, 48'h923C64000000, 1, 1, {8'h3C, 1'b1, 7'h64}};
        vt[5] = '{4, 48'hC2053C640000, 0, 0, 16'h0000};
        vt[6] = '{3, 48'h9F3C00000000, 1, 0, {8'h3C, 1'b0, 7'h00}};
        vt[7] = '{3, 48'hF03C64000000, 0, 0, 16'h0000};
        vt[8] = '{3, 48'h8F7F7F000000, 1, 0, {8'h7F, 1'b0, 7'h7F}};
        vt[9] = '{4, 48'h9210FE000000, 1, 1, {8'h10, 1'b0, 7'h00}};

        hold(4);
        check("reset_omni", {md_o, v_o, on_o, vel_o, fe_o_s}, 0);
        check("reset_ch2", {md_c, v_c, on_c, vel_c, fe_c_s}, 0);
        rst_n = 1'b1;
        hold(2 * CPB);

        for (int v = 0; v < 10; v++) begin
            bo = obs_o.size();
            bc = obs_c.size();
            for (int i = 0; i < vt[v].n; i++) begin
                send_byte(vt[v].b[47-8*i -: 8], 1'b1);
            end
            hold(CPB);
            check($sformatf("vec%0d_omni_cnt", v), obs_o.size() - bo, vt[v].no);
            check($sformatf("vec%0d_ch2_cnt", v), obs_c.size() - bc, vt[v].nc);
            if (vt[v].no > 0 && obs_o.size() > bo) begin
                check($sformatf("vec%0d_omni_ev", v), obs_o[$], vt[v].ev);
                check($sformatf("vec%0d_omni_hold", v), {md_o, on_o, vel_o}, vt[v].ev);
            end
            if (vt[v].nc > 0 && obs_c.size() > bc) begin
                check($sformatf("vec%0d_ch2_ev", v), obs_c[$], vt[v].ev);
            end
            if (v == 0) begin
                d = t_val - t_stop;
                check("latency_window",
                      (d >= CPB / 2 + 2) && (d <= CPB / 2 + 6), 1);
            end
        end

        // Short low glitch: start bit rejected without error.
        fo = fe_cnt_o;
        bo = obs_o.size();
        rx = 1'b0;
        hold(3);
        rx = 1'b1;
        hold(3 * CPB);
        check("glitch_no_err", fe_cnt_o - fo, 0);
        check("glitch_no_ev", obs_o.size() - bo, 0);

        // Low stop bit followed by a 5 ms break.
        fo = fe_cnt_o;
        fc = fe_cnt_c;
        bo = obs_o.size();
        send_byte(8'h90, 1'b0);
        hold(2500 - CPB);
        rx = 1'b1;
        hold(2 * CPB);
        check("break_err_omni", fe_cnt_o - fo, 1);
        check("break_err_ch2", fe_cnt_c - fc, 1);
        check("break_no_ev", obs_o.size() - bo, 0);
        bo = obs_o.size();
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'h64, 1'b1);
        hold(CPB);
        check("recover_cnt", obs_o.size() - bo, 1);
        if (obs_o.size() > bo) begin
            check("recover_ev", obs_o[$], {8'h3C, 1'b1, 7'h64});
        end

        // Reset in the middle of a message.
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        hold(2);
        rst_n = 1'b0;
        hold(1);
        rst_n = 1'b1;
        check("midrst_omni", {md_o, v_o, on_o, vel_o, fe_o_s}, 0);
        check("midrst_ch2", {md_c, v_c, on_c, vel_c, fe_c_s}, 0);
        bo = obs_o.size();
        send_byte(8'h64, 1'b1);
        hold(CPB);
        check("midrst_no_ev", obs_o.size() - bo, 0);

        // Random byte stream against the reference parser.
        rst_n = 1'b0;
        hold(1);
        rst_n = 1'b1;
        hold(CPB);
        rbytes.delete();
        rbytes.push_back(8'h92);
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 11);
            if (k < 2) begin
                d = $urandom_range(0, 4);
                hi = (d == 0) ? 4'h8 : (d < 3) ? 4'h9 : (d == 3) ? 4'hC : 4'hB;
                b = {hi, 4'($urandom_range(0, 3))};
            end else if (k == 2) begin
                b = 8'hF8 + 8'($urandom_range(0, 7));
            end else if (k == 3 && $urandom_range(0, 2) == 0) begin
                b = 8'hF0 + 8'($urandom_range(0, 7));
            end else if (k == 4) begin
                b = 8'h00;
            end else begin
                b = 8'($urandom_range(0, 127));
            end
            rbytes.push_back(b);
        end
        model(rbytes);
        bo = obs_o.size();
        bc = obs_c.size();
        foreach (rbytes[i]) send_byte(rbytes[i], 1'b1);
        hold(CPB);
        check("rand_omni_cnt", obs_o.size() - bo, exp_o.size());
        check("rand_ch2_cnt", obs_c.size() - bc, exp_c.size());
        for (int i = 0; i < exp_o.size(); i++) begin
            if (bo + i < obs_o.size())
                check($sformatf("rand_omni_ev%0d", i), obs_o[bo+i], exp_o[i]);
        end
        for (int i = 0; i < exp_c.size(); i++) begin
            if (bc + i < obs_c.size())
                check($sformatf("rand_ch2_ev%0d", i), obs_c[bc+i], exp_c[i]);
        end

        check("no_back_to_back_valid", bb, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
